// File: rtl/armleocpu_mul_signfix_pkg.sv
// Shared types for the signed multiply front/back end:
// op encodings, FSM states, data width and the magnitude helper.
package armleocpu_mul_signfix_pkg;

  localparam int DATA_W = 32;
  localparam int PROD_W = 2 * DATA_W;

  // Matches funct3[1:0] of the RISC-V M-extension multiplies
  typedef enum logic [1:0] {
    MUL_OP_MUL    = 2'b00,
    MUL_OP_MULH   = 2'b01,
    MUL_OP_MULHSU = 2'b10,
    MUL_OP_MULHU  = 2'b11
  } mul_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_NEG  = 2'b10,
    ST_RESP = 2'b11
  } mul_state_t;

  // 0x80000000 stays 0x80000000, which is the right unsigned magnitude
  function automatic logic [DATA_W-1:0] magnitude(
    input logic [DATA_W-1:0] v,
    input logic              s
  );
    return s ? (~v + {{(DATA_W-1){1'b0}}, 1'b1}) : v;
  endfunction

endpackage

// File: rtl/armleocpu_mul_resultsel.sv
// Conditional 64-bit two's complement negate followed by hi/lo word select.
// Purely combinational; shared by the NEG and RESP paths.
module armleocpu_mul_resultsel
  import armleocpu_mul_signfix_pkg::*;
(
  input  logic [PROD_W-1:0] value,
  input  logic              neg,
  input  mul_op_t           op,
  output logic [PROD_W-1:0] fixed,
  output logic [DATA_W-1:0] data
);

  localparam logic [PROD_W-1:0] ONE = {{(PROD_W-1){1'b0}}, 1'b1};

  assign fixed = neg ? (~value + ONE) : value;

  always_comb begin
    data = fixed[PROD_W-1:DATA_W];
    unique case (op)
      MUL_OP_MUL: data = fixed[DATA_W-1:0];
      MUL_OP_MULH,
      MUL_OP_MULHSU,
      MUL_OP_MULHU: data = fixed[PROD_W-1:DATA_W];
      default: data = fixed[PROD_W-1:DATA_W];
    endcase
  end

endmodule

// File: rtl/armleocpu_mul_signfix.sv
// Signed wrapper around an unsigned 32x32->64 multiplier (MUL/MULH/MULHSU/MULHU).
// Define ARMLEOCPU_MUL_ZERO_BYPASS_EN to skip the multiplier on a zero operand.
module armleocpu_mul_signfix
  import armleocpu_mul_signfix_pkg::*;
#(
  parameter int NEG_STAGE = 1
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [DATA_W-1:0] req_rs1,
  input  logic [DATA_W-1:0] req_rs2,
  output logic              mult_valid,
  output logic [DATA_W-1:0] mult_factor0,
  output logic [DATA_W-1:0] mult_factor1,
  input  logic              mult_ready,
  input  logic [PROD_W-1:0] mult_result,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data
);

  mul_state_t        state;
  mul_state_t        state_nxt;
  mul_op_t           op_in;
  mul_op_t           op_q;
  logic              neg_q;
  logic [DATA_W-1:0] mag_a;
  logic [DATA_W-1:0] mag_b;
  logic [PROD_W-1:0] product;
  logic              sign_a;
  logic              sign_b;
  logic              accept;
  logic              zero_ops;
  logic [PROD_W-1:0] sel_value;
  logic              sel_neg;
  logic [PROD_W-1:0] sel_fixed;
  logic [DATA_W-1:0] sel_data;

  assign op_in  = mul_op_t'(req_op);
  assign accept = (state == ST_IDLE) && req_valid;

  always_comb begin
    sign_a = 1'b0;
    sign_b = 1'b0;
    unique case (1'b1)
      (op_in == MUL_OP_MUL),
      (op_in == MUL_OP_MULH): begin
        sign_a = req_rs1[DATA_W-1];
        sign_b = req_rs2[DATA_W-1];
      end
      (op_in == MUL_OP_MULHSU): begin
        sign_a = req_rs1[DATA_W-1];
      end
      default: begin
        sign_a = 1'b0;
        sign_b = 1'b0;
      end
    endcase
  end

`ifdef ARMLEOCPU_MUL_ZERO_BYPASS_EN
  assign zero_ops = (req_rs1 == '0) || (req_rs2 == '0);
`else
  assign zero_ops = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (req_valid) begin
          state_nxt = zero_ops ? ST_RESP : ST_MUL;
        end
      end
      ST_MUL: begin
        if (mult_ready) begin
          state_nxt = (NEG_STAGE != 0) ? ST_NEG : ST_RESP;
        end
      end
      ST_NEG: begin
        state_nxt = ST_RESP;
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // The raw product passes through the selector while in MUL;
  // otherwise the selector sees the stored product.
  assign sel_value = (state == ST_MUL) ? mult_result : product;

  if (NEG_STAGE != 0) begin : g_neg_stage
    assign sel_neg = neg_q && (state == ST_NEG);
  end else begin : g_neg_inline
    assign sel_neg = neg_q && (state == ST_MUL);
  end

  armleocpu_mul_resultsel u_resultsel (
    .value (sel_value),
    .neg   (sel_neg),
    .op    (op_q),
    .fixed (sel_fixed),
    .data  (sel_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q    <= MUL_OP_MUL;
      neg_q   <= 1'b0;
      mag_a   <= '0;
      mag_b   <= '0;
      product <= '0;
    end else begin
      if (accept) begin
        op_q  <= op_in;
        neg_q <= sign_a ^ sign_b;
        mag_a <= magnitude(req_rs1, sign_a);
        mag_b <= magnitude(req_rs2, sign_b);
        if (zero_ops) begin
          product <= '0;
        end
      end
      if ((state == ST_MUL) && mult_ready) begin
        product <= sel_fixed;
      end
      if (state == ST_NEG) begin
        product <= sel_fixed;
      end
    end
  end

  assign req_ready    = (state == ST_IDLE);
  assign mult_valid   = (state == ST_MUL);
  assign mult_factor0 = mag_a;
  assign mult_factor1 = mag_b;
  assign resp_valid   = (state == ST_RESP);
  assign resp_data    = resp_valid ? sel_data : '0;

endmodule

// File: tb/tb_armleocpu_mul_signfix.sv
// Table-driven bench with a response scoreboard and a behavioural multiplier
// whose ready delay is adjustable, plus stall and reset sequences.
module tb_armleocpu_mul_signfix;
  import armleocpu_mul_signfix_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'b00;
  logic [31:0] req_rs1 = '0;
  logic [31:0] req_rs2 = '0;
  logic        mult_valid;
  logic [31:0] mult_factor0;
  logic [31:0] mult_factor1;
  logic        mult_ready = 1'b0;
  logic [63:0] mult_result = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_data;

  always #5 clk = ~clk;

  armleocpu_mul_signfix #(.NEG_STAGE(1)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_rs1      (req_rs1),
    .req_rs2      (req_rs2),
    .mult_valid   (mult_valid),
    .mult_factor0 (mult_factor0),
    .mult_factor1 (mult_factor1),
    .mult_ready   (mult_ready),
    .mult_result  (mult_result),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_data    (resp_data)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] data;
    logic [31:0] f0;
    logic [31:0] f1;
  } vec_t;

  vec_t        vecs[10];
  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_q[$];
  int          mdelay = 0;
  int          mcnt = 0;
  int          mv_cycles = 0;
  int          resp_cnt = 0;
  logic        force_ready = 1'b0;

`ifdef ARMLEOCPU_MUL_ZERO_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  // Unsigned multiplier: ready after mdelay extra cycles of valid
  always @(negedge clk) begin
    if (!rst && mult_valid) begin
      mult_result = {32'd0, mult_factor0} * {32'd0, mult_factor1};
      mult_ready  = (mcnt == mdelay) || force_ready;
      mcnt++;
      mv_cycles++;
    end else begin
      mult_ready = force_ready;
      mcnt = 0;
    end
  end

  always @(negedge clk) begin
    if (!rst && resp_valid && resp_ready) begin
      resp_cnt++;
      if (exp_q.size() == 0) check1("unexpected_resp", 1'b1, 1'b0);
      else check("resp_data", resp_data, exp_q.pop_front());
    end
  end

  task automatic run_op(input string name, input logic [1:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] data, input logic [31:0] f0,
                        input logic [31:0] f1, input int exp_lat,
                        input int exp_mv);
    int lat;
    int rc0;
    bit seen_mv;
    bit done;
    lat = 0;
    seen_mv = 1'b0;
    done = 1'b0;
    @(posedge clk);
    #1;
    check1({name, "_req_ready"}, req_ready, 1'b1);
    req_valid = 1'b1;
    req_op = op;
    req_rs1 = a;
    req_rs2 = b;
    exp_q.push_back(data);
    mv_cycles = 0;
    rc0 = resp_cnt;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      lat++;
      if (mult_valid && !seen_mv) begin
        seen_mv = 1'b1;
        check({name, "_f0"}, mult_factor0, f0);
        check({name, "_f1"}, mult_factor1, f1);
      end
      if (resp_valid) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      check1({name, "_timeout"}, 1'b0, 1'b1);
      exp_q.delete();
    end else begin
      check({name, "_latency"}, 32'(lat), 32'(exp_lat));
    end
    @(posedge clk);
    #1;
    check({name, "_resp_count"}, 32'(resp_cnt - rc0), 32'd1);
    check({name, "_mv_cycles"}, 32'(mv_cycles), 32'(exp_mv));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int rcyc;
    int rc0;

    vecs[0] = '{2'b00, 32'd64,        32'd53,        32'h00000D40, 32'd64,        32'd53};
    vecs[1] = '{2'b11, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'hFFFFFFFE, 32'hFFFFFFFF,  32'hFFFFFFFF};
    vecs[2] = '{2'b00, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'h00000001, 32'd1,         32'd1};
    vecs[3] = '{2'b01, 32'hFFFFFFFE,  32'd3,         32'hFFFFFFFF, 32'd2,         32'd3};
    vecs[4] = '{2'b00, 32'hFFFFFFFE,  32'd3,         32'hFFFFFFFA, 32'd2,         32'd3};
    vecs[5] = '{2'b01, 32'h80000000,  32'h80000000,  32'h40000000, 32'h80000000,  32'h80000000};
    vecs[6] = '{2'b10, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'hFFFFFFFF, 32'd1,         32'hFFFFFFFF};
    vecs[7] = '{2'b10, 32'hFFFFFFFF,  32'h80000000,  32'hFFFFFFFF, 32'd1,         32'h80000000};
    vecs[8] = '{2'b11, 32'h80000000,  32'd2,         32'h00000001, 32'h80000000,  32'd2};
    vecs[9] = '{2'b01, 32'h7FFFFFFF,  32'h7FFFFFFF,  32'h3FFFFFFF, 32'h7FFFFFFF,  32'h7FFFFFFF};

    #2;
    check1("rst_req_ready", req_ready, 1'b1);
    check1("rst_mult_valid", mult_valid, 1'b0);
    check("rst_f0", mult_factor0, 32'd0);
    check("rst_f1", mult_factor1, 32'd0);
    check1("rst_resp_valid", resp_valid, 1'b0);
    check("rst_resp_data", resp_data, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].data, vecs[i].f0, vecs[i].f1, 3, 1);
    end

    // Multiplier stall plus response backpressure
    @(posedge clk);
    #1;
    mdelay = 5;
    resp_ready = 1'b0;
    check1("stall_req_ready0", req_ready, 1'b1);
    req_valid = 1'b1;
    req_op = 2'b00;
    req_rs1 = 32'd64;
    req_rs2 = 32'd53;
    exp_q.push_back(32'h00000D40);
    mv_cycles = 0;
    rc0 = resp_cnt;
    rcyc = 0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      check1("stall_req_ready", req_ready, 1'b0);
      if (mult_valid) begin
        check("stall_f0", mult_factor0, 32'd64);
        check("stall_f1", mult_factor1, 32'd53);
      end
      if (resp_valid) begin
        rcyc++;
        check("stall_hold_data", resp_data, 32'h00000D40);
        if (rcyc == 3) break;
      end
    end
    check("stall_resp_hold", 32'(rcyc), 32'd3);
    @(posedge clk);
    #1;
    resp_ready = 1'b1;
    @(negedge clk);
    check1("stall_resp_valid", resp_valid, 1'b1);
    @(posedge clk);
    #1;
    check1("stall_done_ready", req_ready, 1'b1);
    check("stall_resp_count", 32'(resp_cnt - rc0), 32'd1);
    check("stall_mv_cycles", 32'(mv_cycles), 32'd6);
    mdelay = 0;

    // Reset in the middle of a multiply
    mdelay = 10;
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_op = 2'b00;
    req_rs1 = 32'd64;
    req_rs2 = 32'd53;
    exp_q.push_back(32'h00000D40);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    check1("pre_rst_mult_valid", mult_valid, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check1("mid_rst_mult_valid", mult_valid, 1'b0);
    check("mid_rst_f0", mult_factor0, 32'd0);
    check("mid_rst_f1", mult_factor1, 32'd0);
    check1("mid_rst_resp_valid", resp_valid, 1'b0);
    check("mid_rst_resp_data", resp_data, 32'd0);
    check1("mid_rst_req_ready", req_ready, 1'b1);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    mdelay = 0;
    @(posedge clk);
    #1;
    force_ready = 1'b1;
    mult_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check1("late_ready_mult_valid", mult_valid, 1'b0);
      check1("late_ready_resp_valid", resp_valid, 1'b0);
      check1("late_ready_req_ready", req_ready, 1'b1);
    end
    @(posedge clk);
    #1;
    force_ready = 1'b0;
    mult_ready = 1'b0;

    run_op("mul7x6", 2'b00, 32'd7, 32'd6, 32'd42, 32'd7, 32'd6, 3, 1);
    run_op("mul0x5", 2'b00, 32'd0, 32'd5, 32'd0, 32'd0, 32'd5,
           BYPASS ? 1 : 3, BYPASS ? 0 : 1);
    run_op("mulhu5x0", 2'b11, 32'd5, 32'd0, 32'd0, 32'd5, 32'd0,
           BYPASS ? 1 : 3, BYPASS ? 0 : 1);

    repeat (3) @(posedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/armleocpu_mul_signfix.md
Name: armleocpu_mul_signfix

Overview:
Signed-operation front/back end for the unsigned 32x32->64 multiplier. Accepts RISC-V M-extension multiply requests (MUL/MULH/MULHSU/MULHU), converts signed operands to magnitudes, and drives the multiplier's valid/factor0/factor1 interface. It then takes the 64-bit unsigned product, applies the sign correction, selects the low or high word, and returns it to the execute stage over a valid/ready handshake.

Parameters:
NEG_STAGE, 1, 1 = register the 64-bit conditional negation in its own cycle (NEG state); 0 = negate combinationally on capture.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  request accepted when req_valid&&req_ready
req_op  in  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU (= funct3[1:0])
req_rs1  in  32  operand A
req_rs2  in  32  operand B
mult_valid  out  1  to multiplier valid
mult_factor0  out  32  magnitude of A
mult_factor1  out  32  magnitude of B
mult_ready  in  1  multiplier result valid this cycle
mult_result  in  64  unsigned product
resp_valid  out  1  result available
resp_ready  in  1  consumer accepts result
resp_data  out  32  selected 32-bit result

Behaviour:
- States: IDLE, MUL, NEG (only if NEG_STAGE=1), RESP. Reset -> IDLE asynchronously from any state; an in-flight op is discarded.
- Reset values: mult_valid=0, mult_factor0/1=0, resp_valid=0, resp_data=0. req_ready = (state==IDLE), so it is 1 after reset.
- IDLE: on req_valid, latch the following, then go to MUL:
  - op.
  - sign_a = rs1[31] if op in {MUL, MULH, MULHSU}, else 0. sign_b = rs2[31] if op in {MUL, MULH}, else 0.
  - mag_a = sign_a ? -rs1 : rs1, and likewise mag_b (32-bit two's complement; 0x80000000 maps to 0x80000000, which is correct as unsigned).
  - neg = sign_a ^ sign_b.
- MUL: mult_valid=1, factors held constant from registers until mult_ready.
  - On mult_ready, capture mult_result into a 64-bit product register.
  - mult_valid drops on the next cycle; it is never reasserted for the same op.
  - A mult_ready arriving while state!=MUL is ignored.
- NEG: if neg, product <= ~product + 1 (64-bit, carry beyond bit 63 discarded). Go to RESP.
- RESP: resp_valid=1, resp_data = op==MUL ? product[31:0] : product[63:32]. resp_data is held stable until resp_ready; then go to IDLE.
- No new request is accepted in the IDLE-exit cycle; there is no back-to-back overlap.
- Latency, with a 1-cycle multiplier and resp_ready=1: accept at cycle 0, MUL at cycle 1, NEG at cycle 2, RESP at cycle 3 (cycle 2 when NEG_STAGE=0). Multiplier stalls extend MUL cycle-for-cycle.
- MUL low word is sign-independent, but sign handling is still applied uniformly so every op uses one datapath.

Optional Feature:
ARMLEOCPU_MUL_ZERO_BYPASS_EN
- Defined: in IDLE, if rs1==0 or rs2==0, skip MUL/NEG: product <= 0 and go straight to RESP. mult_valid is never asserted for that op. Latency is 1 cycle to RESP.
- Undefined: zero operands take the normal multiplier path; results are identical.

Decomposition:
- Shared package/defines header: op encodings (MUL_OP_MUL/MULH/MULHSU/MULHU, 2-bit), state encoding constants, and a DATA_W=32 localparam.
- One natural sub-module: armleocpu_mul_resultsel. It is combinational: 64-bit conditional negate plus hi/lo select. It is instantiated once and reused by NEG/RESP regardless of NEG_STAGE.

Test Plan:
- MUL 64*53 with multiplier ready 1 cycle after valid -> mult_factor0=64, mult_factor1=53, resp_data=0x00000D40, resp_valid at cycle 3.
- MULHU 0xFFFFFFFF*0xFFFFFFFF -> mult_result 0xFFFFFFFE00000001 -> resp_data=0xFFFFFFFE. MUL on the same operands -> 0x00000001.
- MULH -2*3 -> factors 2,3, neg=1 -> resp_data=0xFFFFFFFF. MUL -2*3 -> 0xFFFFFFFA. MULH 0x80000000*0x80000000 -> 0x40000000.
- MULHSU rs1=0xFFFFFFFF, rs2=0xFFFFFFFF -> factors 1, 0xFFFFFFFF, product 0xFFFFFFFF00000001 -> resp_data=0xFFFFFFFF.
- Backpressure and stall: mult_ready delayed 5 cycles and resp_ready held 0 for 3 cycles in RESP -> mult_valid/factors stable for 6 cycles; resp_valid/resp_data stable; req_ready=0 throughout; one response only.
- rst pulsed while in MUL -> all outputs immediately at reset values. A late mult_ready is ignored. A new MUL 7*6 then returns 42; with ZERO_BYPASS_EN, MUL 0*5 returns 0 with mult_valid never high.
